// File: rtl/pll_cfg_pkg.sv
// pll_cfg_pkg
// Shared constants for the PLL configuration serialiser:
//   - FSM state encoding (plain localparams so older tools can read it)
//   - default shift-chain length
//   - depth of the pll_locked synchroniser
package pll_cfg_pkg;

  localparam int DEF_CFG_BITS = 26;
  localparam int SYNC_STAGES  = 2;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RST_HOLD  = 3'd1;
  localparam logic [2:0] ST_SH_LO     = 3'd2;
  localparam logic [2:0] ST_SH_HI     = 3'd3;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd4;
  localparam logic [2:0] ST_FINISH    = 3'd5;

endpackage

// File: rtl/pll_cfg_tick.sv
// pll_cfg_tick
// Phase timer for the serialiser. Counts CLK_DIV cycles per phase and flags
// the last cycle of each phase.
// Ports:
//   clk     in   system clock
//   reset   in   synchronous, active-high
//   enable  in   count only while a timed phase is active; otherwise held at 0
//   restart in   force the count back to 0 (used on every state change)
//   last    out  high on the final cycle of the current phase
module pll_cfg_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic last
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST_VAL = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  // Count 0..CLK_DIV-1 and wrap; a state change restarts the phase so the
  // next phase always gets its full CLK_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (!enable || restart || last) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign last = enable && (count == LAST_VAL);

endmodule

// File: rtl/pll_cfg_ser.sv
// pll_cfg_ser
// Loads a configuration word into the pixel-clock PLL over its serial pins
// and runs the reset / lock sequence. The previous chain contents come back
// on pll_sdo during the same transfer and are reported on rd_data.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start, cfg_data   one-cycle request and the word to send (MSB first)
//   busy, done        sequence in progress / one-cycle end pulse
//   status_locked     last sequence ended with lock
//   status_timeout    last sequence ended without lock
//   rd_data           word shifted out of pll_sdo during the last sequence
//   pll_nreset        PLL reset (active-low)
//   pll_sclk, pll_sdi PLL config clock and data
//   pll_sdo           PLL config data out
//   pll_locked        PLL lock indication, asynchronous to clk
module pll_cfg_ser
  import pll_cfg_pkg::*;
#(
  parameter int CFG_BITS     = DEF_CFG_BITS,
  parameter int CLK_DIV      = 4,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CFG_BITS-1:0] cfg_data,
  output logic                busy,
  output logic                done,
  output logic                status_locked,
  output logic                status_timeout,
  output logic [CFG_BITS-1:0] rd_data,
  output logic                pll_nreset,
  output logic                pll_sclk,
  output logic                pll_sdi,
  input  logic                pll_sdo,
  input  logic                pll_locked
);

  localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [BW-1:0] BIT_TOP     = BW'(CFG_BITS - 1);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(LOCK_TIMEOUT);

  logic [2:0]             state;
  logic [2:0]             state_next;
  logic [CFG_BITS-1:0]    cfg_shift;
  logic [CFG_BITS-1:0]    rd_shift;
  logic [BW-1:0]          bit_cnt;
  logic [TW-1:0]          timer;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   locked_s;
  logic                   phase_last;
  logic                   phase_en;
  logic                   phase_restart;

  assign locked_s      = lock_sync[SYNC_STAGES-1];
  assign phase_en      = (state == ST_RST_HOLD) || (state == ST_SH_LO) ||
                         (state == ST_SH_HI);
  assign phase_restart = (state_next != state);

  pll_cfg_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .enable  (phase_en),
    .restart (phase_restart),
    .last    (phase_last)
  );

  // Lock wins over timeout when both happen in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (start) state_next = ST_RST_HOLD;
      ST_RST_HOLD:  if (phase_last) state_next = ST_SH_LO;
      ST_SH_LO:     if (phase_last) state_next = ST_SH_HI;
      ST_SH_HI:     if (phase_last) state_next = (bit_cnt == '0) ? ST_WAIT_LOCK : ST_SH_LO;
      ST_WAIT_LOCK: if (locked_s || (timer == TIMEOUT_VAL)) state_next = ST_FINISH;
      ST_FINISH:    state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Pin outputs are registered and updated on the edge that enters the new
  // phase, so sdi only moves together with sclk falling and never while it
  // is high. rd_data and status are loaded on entry to FINISH so they are
  // already valid while done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      cfg_shift      <= '0;
      rd_shift       <= '0;
      bit_cnt        <= '0;
      timer          <= '0;
      lock_sync      <= '0;
      status_locked  <= 1'b0;
      status_timeout <= 1'b0;
      rd_data        <= '0;
      pll_nreset     <= 1'b0;
      pll_sclk       <= 1'b0;
      pll_sdi        <= 1'b0;
    end else begin
      state     <= state_next;
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
      case (state)
        ST_IDLE: begin
          if (start) begin
            cfg_shift      <= cfg_data;
            rd_shift       <= '0;
            status_locked  <= 1'b0;
            status_timeout <= 1'b0;
            pll_nreset     <= 1'b0;
          end
        end
        ST_RST_HOLD: begin
          if (phase_last) begin
            bit_cnt <= BIT_TOP;
            pll_sdi <= cfg_shift[CFG_BITS-1];
          end
        end
        ST_SH_LO: begin
          if (phase_last) pll_sclk <= 1'b1;
        end
        ST_SH_HI: begin
          if (phase_last) begin
            rd_shift  <= {rd_shift[CFG_BITS-2:0], pll_sdo};
            cfg_shift <= {cfg_shift[CFG_BITS-2:0], 1'b0};
            pll_sclk  <= 1'b0;
            if (bit_cnt == '0) begin
              pll_nreset <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt - BW'(1);
              pll_sdi <= cfg_shift[CFG_BITS-2];
            end
          end
        end
        ST_WAIT_LOCK: begin
          timer <= timer + TW'(1);
          if (locked_s) begin
            status_locked <= 1'b1;
            rd_data       <= rd_shift;
            timer         <= '0;
          end else if (timer == TIMEOUT_VAL) begin
            status_timeout <= 1'b1;
            rd_data        <= rd_shift;
            timer          <= '0;
          end
        end
        ST_FINISH: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FINISH);

endmodule

// File: tb/tb_pll_cfg_ser.sv
// tb_pll_cfg_ser
// Drives two serialisers (CLK_DIV=4 and the minimum CLK_DIV=2) against a
// behavioural PLL shift chain and lock model. Expected timing is computed
// from cycle arithmetic on the start cycle; expected chain contents come
// from the PLL model state.
module tb_pll_cfg_ser;

  localparam int CB  = 26;
  localparam int CD  = 4;
  localparam int LT  = 100;
  localparam int CD2 = 2;
  localparam int LT2 = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start, busy, done, status_locked, status_timeout;
  logic          pll_nreset, pll_sclk, pll_sdi, pll_sdo, pll_locked;
  logic [CB-1:0] cfg_data, rd_data;

  logic          start2, busy2, done2, status_locked2, status_timeout2;
  logic          pll_nreset2, pll_sclk2, pll_sdi2, pll_sdo2;
  logic          pll_locked2 = 1'b0;
  logic [CB-1:0] cfg2, rd_data2;

  pll_cfg_ser #(.CFG_BITS(CB), .CLK_DIV(CD), .LOCK_TIMEOUT(LT)) u_dut (
    .clk(clk), .reset(reset), .start(start), .cfg_data(cfg_data),
    .busy(busy), .done(done), .status_locked(status_locked),
    .status_timeout(status_timeout), .rd_data(rd_data),
    .pll_nreset(pll_nreset), .pll_sclk(pll_sclk), .pll_sdi(pll_sdi),
    .pll_sdo(pll_sdo), .pll_locked(pll_locked)
  );

  pll_cfg_ser #(.CFG_BITS(CB), .CLK_DIV(CD2), .LOCK_TIMEOUT(LT2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .cfg_data(cfg2),
    .busy(busy2), .done(done2), .status_locked(status_locked2),
    .status_timeout(status_timeout2), .rd_data(rd_data2),
    .pll_nreset(pll_nreset2), .pll_sclk(pll_sclk2), .pll_sdi(pll_sdi2),
    .pll_sdo(pll_sdo2), .pll_locked(pll_locked2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic model_en = 1'b0;

  // Free-running cycle number; stable when sampled on the falling edge.
  always @(posedge clk) cyc <= cyc + 1;

  // PLL shift chain model: sdi captured on sclk rise, chain shifts on sclk
  // fall, sdo is the chain MSB.
  logic [CB-1:0] chain = 26'h155_5555;
  logic [CB-1:0] rx_word = '0;
  logic          cap_bit = 1'b0;
  int            rises = 0;
  always @(posedge pll_sclk) if (model_en) begin
    cap_bit = pll_sdi;
    rx_word = {rx_word[CB-2:0], pll_sdi};
    rises++;
  end
  always @(negedge pll_sclk) if (model_en) chain = {chain[CB-2:0], cap_bit};
  assign pll_sdo = chain[CB-1];

  logic [CB-1:0] chain2 = 26'h3C3_C3C3;
  logic [CB-1:0] rx2 = '0;
  logic          cap2 = 1'b0;
  int            rises2 = 0;
  always @(posedge pll_sclk2) if (model_en) begin
    cap2 = pll_sdi2;
    rx2 = {rx2[CB-2:0], pll_sdi2};
    rises2++;
  end
  always @(negedge pll_sclk2) if (model_en) chain2 = {chain2[CB-2:0], cap2};
  assign pll_sdo2 = chain2[CB-1];

  // Lock model: lock_mode 1 raises lock lock_delay cycles after nreset rises;
  // lock_force and lock_glitch are driven directly by the stimulus.
  int   lock_mode = 0;
  int   lock_delay = 10;
  logic lock_auto = 1'b0;
  logic lock_force = 1'b0;
  logic lock_glitch = 1'b0;
  logic nres_prev = 1'b0;
  int   rise_cyc = -1;
  int   done_count = 0;
  assign pll_locked = lock_auto | lock_force | lock_glitch;

  always @(negedge clk) begin
    if (pll_nreset === 1'b1 && nres_prev !== 1'b1) rise_cyc = cyc;
    nres_prev = pll_nreset;
    if (done === 1'b1) done_count++;
    lock_auto = (lock_mode == 1) && (pll_nreset === 1'b1) && (cyc - rise_cyc >= lock_delay);
  end

  // Watch the CLK_DIV=2 pins: every high phase and every low phase between
  // two highs lasts exactly CLK_DIV cycles, and sdi holds while sclk is high.
  int   hi_run = 0;
  int   lo_run = 0;
  int   seq_rises2 = 0;
  logic sclk2_prev = 1'b0;
  logic sdi2_prev = 1'b0;
  always @(negedge clk) if (model_en) begin
    if (pll_sclk2 && !sclk2_prev) begin
      if (seq_rises2 > 0) checkOutput("sclk2_low_len", lo_run, CD2);
      seq_rises2++;
      hi_run = 1;
    end else if (pll_sclk2) begin
      hi_run++;
      checkOutput("sdi2_stable_hi", pll_sdi2, sdi2_prev);
    end else if (sclk2_prev) begin
      checkOutput("sclk2_high_len", hi_run, CD2);
      lo_run = 1;
    end else begin
      lo_run++;
    end
    if (!busy2) seq_rises2 = 0;
    sclk2_prev = pll_sclk2;
    sdi2_prev  = pll_sdi2;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkRange(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("[TB] FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic logic [CB-1:0] rand26();
    logic [31:0] r;
    r = $urandom;
    return r[CB-1:0];
  endfunction

  int            rises_base = 0;
  int            done_base = 0;
  int            n_start = 0;
  logic [CB-1:0] prev_chain = '0;

  // Pulse start for one cycle; cfg_data is scrambled afterwards so a late
  // sample of it would be caught.
  task automatic applyStimulus(input logic [CB-1:0] data);
    @(negedge clk);
    start      = 1'b1;
    cfg_data   = data;
    n_start    = cyc;
    prev_chain = chain;
    rises_base = rises;
    done_base  = done_count;
    @(negedge clk);
    start    = 1'b0;
    cfg_data = ~data;
  endtask

  task automatic waitRises(input int k);
    int n = 0;
    while ((rises - rises_base) < k && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rises_reached", ((rises - rises_base) >= k), 1);
  endtask

  // One full sequence on the CLK_DIV=4 unit. mid: 0 none, 1 lock glitch,
  // 2 second start with other data, 3 lock forced high before nreset rises.
  task automatic runSeq(input logic [CB-1:0] data, input logic exp_lock,
                        input int lat_lo, input int lat_hi, input int mid);
    int w;
    int d = -1;
    int n = 0;
    applyStimulus(data);
    checkOutput("start_busy", busy, 1);
    checkOutput("start_nreset", pll_nreset, 0);
    checkOutput("start_status", {status_locked, status_timeout}, 0);
    if (mid != 0) begin
      waitRises(10);
      if (mid == 1) begin
        #3 lock_glitch = 1'b1;
        #4 lock_glitch = 1'b0;
      end else if (mid == 2) begin
        start = 1'b1;
        cfg_data = ~data;
        @(negedge clk);
        start = 1'b0;
      end else begin
        lock_force = 1'b1;
      end
    end
    while (d < 0 && n < LT + 2 * CD * CB + 50) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) d = cyc;
    end
    checkOutput("done_seen", (d >= 0), 1);
    w = n_start + 1 + CD + 2 * CD * CB;
    checkOutput("nreset_rise_cyc", rise_cyc, w);
    checkRange("done_latency", d - w, lat_lo, lat_hi);
    checkOutput("sclk_rises", rises - rises_base, CB);
    checkOutput("sdi_word", rx_word, data);
    checkOutput("rd_data", rd_data, prev_chain);
    checkOutput("status", {status_locked, status_timeout}, exp_lock ? 2'b10 : 2'b01);
    checkOutput("done_busy", busy, 1);
    start = 1'b1;
    cfg_data = rand26();
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_done_fall", {busy, done}, 2'b00);
    checkOutput("nreset_held", pll_nreset, 1);
    checkOutput("single_done", done_count - done_base, 1);
  endtask

  int            n2, d2, w2, base2;
  logic [CB-1:0] data2, prev2;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    cfg_data = '0;
    start2 = 1'b0;
    cfg2 = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_outs", {busy, done, status_locked, status_timeout, pll_nreset, pll_sclk, pll_sdi}, 0);
    checkOutput("rst_rd", rd_data, 0);
    checkOutput("rst_outs2", {busy2, done2, status_locked2, status_timeout2, pll_nreset2, pll_sclk2, pll_sdi2}, 0);
    model_en = 1'b1;
    reset = 1'b0;

    $display("[TB] directed word, lock 10 cycles after nreset");
    lock_mode = 1;
    lock_delay = 10;
    runSeq(26'h2AB_CDEF, 1'b1, 13, 13, 0);

    $display("[TB] no lock with mid-shift glitch -> timeout");
    lock_mode = 0;
    runSeq(rand26(), 1'b0, LT + 1, LT + 3, 1);

    $display("[TB] second start mid-shift is dropped");
    lock_mode = 1;
    runSeq(rand26(), 1'b1, 13, 13, 2);

    $display("[TB] reset at bit 10");
    applyStimulus(rand26());
    waitRises(10);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_nreset", pll_nreset, 0);
    checkOutput("midrst_sclk", pll_sclk, 0);
    checkOutput("midrst_outs", {done, status_locked, status_timeout, pll_sdi}, 0);
    checkOutput("midrst_rd", rd_data, 0);
    start = 1'b1;
    cfg_data = rand26();
    @(negedge clk);
    checkOutput("rst_beats_start", busy, 0);
    reset = 1'b0;
    start = 1'b0;
    runSeq(rand26(), 1'b1, 13, 13, 0);

    $display("[TB] lock held before nreset rises");
    lock_mode = 0;
    runSeq(rand26(), 1'b1, 1, 3, 3);
    lock_force = 1'b0;

    $display("[TB] random words and lock delays");
    lock_mode = 1;
    for (int i = 0; i < 3; i++) begin
      lock_delay = int'($urandom_range(1, 20));
      runSeq(rand26(), 1'b1, lock_delay + 3, lock_delay + 3, 0);
    end

    $display("[TB] CLK_DIV=2 unit, no lock");
    data2 = rand26();
    @(negedge clk);
    prev2 = chain2;
    base2 = rises2;
    start2 = 1'b1;
    cfg2 = data2;
    n2 = cyc;
    @(negedge clk);
    start2 = 1'b0;
    cfg2 = ~data2;
    checkOutput("d2_busy", busy2, 1);
    d2 = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done2 === 1'b1) begin
        d2 = cyc;
        break;
      end
    end
    checkOutput("d2_done_seen", (d2 >= 0), 1);
    w2 = n2 + 1 + CD2 + 2 * CD2 * CB;
    checkRange("d2_timeout_lat", d2 - w2, LT2 + 1, LT2 + 3);
    checkOutput("d2_rises", rises2 - base2, CB);
    checkOutput("d2_sdi_word", rx2, data2);
    checkOutput("d2_rd_data", rd_data2, prev2);
    checkOutput("d2_status", {status_locked2, status_timeout2}, 2'b01);
    @(negedge clk);
    checkOutput("d2_busy_fall", busy2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
